// File: rtl/keypad_pkg.sv
// Shared key-code definitions for the keypad scanner and the entry buffer.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE = 5'b11111;
    localparam logic [4:0] KEY_STAR = 5'd16;
    localparam logic [4:0] KEY_ZERO = 5'd17;
    localparam logic [4:0] KEY_HASH = 5'd18;

    // Qualifier FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HELD = 2'd2,
        ST_RELQ = 2'd3
    } qual_state_t;

    // A code is a real key: digits 1-13 plus *, 0 and #.
    function automatic logic is_valid_code(input logic [4:0] code);
        return ((code >= 5'd1) && (code <= 5'd13)) ||
               (code == KEY_STAR) || (code == KEY_ZERO) || (code == KEY_HASH);
    endfunction

    // Keys that contribute a hex nibble to the entry.
    function automatic logic is_digit_code(input logic [4:0] code);
        return ((code >= 5'd1) && (code <= 5'd13)) || (code == KEY_ZERO);
    endfunction

    // Hex nibble for a digit key; the 0 key has its own code.
    function automatic logic [3:0] code_to_nibble(input logic [4:0] code);
        return (code == KEY_ZERO) ? 4'h0 : code[3:0];
    endfunction

endpackage

// File: rtl/key_qualifier.sv
// Press/release qualifier: a key is accepted once after STABLE_CYCLES
// identical samples and re-armed only after STABLE_CYCLES "none" samples.
module key_qualifier
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] decoded,
    output logic       accept_pulse,
    output logic [4:0] accepted_code
);

    localparam logic [3:0] STABLE_W = 4'(STABLE_CYCLES);

    qual_state_t state_q, state_d;
    logic [4:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc;

    assign cnt_inc = cnt_q + 4'd1;

    // State, candidate and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= KEY_NONE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; accept is combinational so the top acts on the same edge
    // that takes the final qualifying sample.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        accept_pulse  = 1'b0;
        accepted_code = cand_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (is_valid_code(decoded)) begin
                    state_d = ST_QUAL;
                    cand_d  = decoded;
                    cnt_d   = 4'd1;
                end
            end
            ST_QUAL: begin
                if (decoded == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == STABLE_W) begin
                        accept_pulse = 1'b1;
                        state_d      = ST_HELD;
                        cnt_d        = 4'd0;
                    end
                end else if (is_valid_code(decoded)) begin
                    cand_d = decoded;
                    cnt_d  = 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_HELD: begin
                if (decoded == KEY_NONE) begin
                    state_d = ST_RELQ;
                    cnt_d   = 4'd1;
                end
            end
            ST_RELQ: begin
                if (decoded == KEY_NONE) begin
                    if (cnt_inc == STABLE_W) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    // Release bounced: the key is still considered held.
                    state_d = ST_HELD;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Builds a multi-digit hex entry from qualified key presses:
// digits shift in at the low nibble, * clears, # commits.
module keypad_entry_buffer
    import keypad_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            decoded,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            digit_count,
    output logic [4*DIGITS-1:0]   committed,
    output logic                  commit_valid,
    output logic                  key_strobe,
    output logic [4:0]            key_code,
    output logic                  overflow
);

    localparam int         EW       = 4 * DIGITS;
    localparam logic [3:0] DIGITS_W = 4'(DIGITS);

    logic          accept_pulse;
    logic [4:0]    accepted_code;

    logic [EW-1:0] entry_q, entry_d;
    logic [3:0]    count_q, count_d;
    logic [EW-1:0] committed_q, committed_d;
    logic          commit_valid_q, commit_valid_d;
    logic          key_strobe_q, key_strobe_d;
    logic [4:0]    key_code_q, key_code_d;
    logic          overflow_q, overflow_d;

    key_qualifier #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_qual (
        .clk           (clk),
        .rst           (rst),
        .decoded       (decoded),
        .accept_pulse  (accept_pulse),
        .accepted_code (accepted_code)
    );

    // Entry/commit datapath; pulses default low and fire only on an accept.
    always_comb begin
        entry_d        = entry_q;
        count_d        = count_q;
        committed_d    = committed_q;
        commit_valid_d = 1'b0;
        key_strobe_d   = 1'b0;
        key_code_d     = key_code_q;
        overflow_d     = 1'b0;
        if (accept_pulse) begin
            key_strobe_d = 1'b1;
            key_code_d   = accepted_code;
            if (is_digit_code(accepted_code)) begin
                if (count_q < DIGITS_W) begin
                    entry_d = (entry_q << 4) | EW'(code_to_nibble(accepted_code));
                    count_d = count_q + 4'd1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (accepted_code == KEY_STAR) begin
                entry_d = '0;
                count_d = 4'd0;
            end else if (accepted_code == KEY_HASH) begin
                // An empty entry is never committed.
                if (count_q != 4'd0) begin
                    committed_d    = entry_q;
                    commit_valid_d = 1'b1;
                    entry_d        = '0;
                    count_d        = 4'd0;
                end
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q        <= '0;
            count_q        <= 4'd0;
            committed_q    <= '0;
            commit_valid_q <= 1'b0;
            key_strobe_q   <= 1'b0;
            key_code_q     <= KEY_NONE;
            overflow_q     <= 1'b0;
        end else begin
            entry_q        <= entry_d;
            count_q        <= count_d;
            committed_q    <= committed_d;
            commit_valid_q <= commit_valid_d;
            key_strobe_q   <= key_strobe_d;
            key_code_q     <= key_code_d;
            overflow_q     <= overflow_d;
        end
    end

    assign entry        = entry_q;
    assign digit_count  = count_q;
    assign committed    = committed_q;
    assign commit_valid = commit_valid_q;
    assign key_strobe   = key_strobe_q;
    assign key_code     = key_code_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Scenario and randomized bench for keypad_entry_buffer with a run-length
// reference model of key acceptance.
module tb_keypad_entry_buffer;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;
    localparam int EW     = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    decoded = 5'd31;
    logic [EW-1:0] entry;
    logic [3:0]    digit_count;
    logic [EW-1:0] committed;
    logic          commit_valid;
    logic          key_strobe;
    logic [4:0]    key_code;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit     armed;
    int     run_val;
    int     run_len;
    longint m_entry;
    int     m_count;
    longint m_committed;
    bit     m_cv, m_ks, m_ovf;
    int     m_code;

    // Observed pulse totals
    int obs_strobes, obs_commits, obs_ovf;

    keypad_entry_buffer #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .decoded      (decoded),
        .entry        (entry),
        .digit_count  (digit_count),
        .committed    (committed),
        .commit_valid (commit_valid),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic bit tb_valid(input int d);
        return (d >= 1 && d <= 13) || d == 16 || d == 17 || d == 18;
    endfunction

    task automatic model_reset();
        armed = 1; run_val = -1; run_len = 0;
        m_entry = 0; m_count = 0; m_committed = 0;
        m_cv = 0; m_ks = 0; m_ovf = 0; m_code = 31;
    endtask

    // A press counts when a valid code has been seen STABLE times in a row
    // while armed; re-arming needs STABLE consecutive "none" samples.
    task automatic model_step(input int d);
        m_cv = 0; m_ks = 0; m_ovf = 0;
        if (d == run_val) run_len++;
        else begin run_val = d; run_len = 1; end
        if (armed) begin
            if (tb_valid(d) && run_len == STABLE) begin
                armed = 0;
                m_ks = 1; m_code = d;
                if ((d >= 1 && d <= 13) || d == 17) begin
                    if (m_count < DIGITS) begin
                        m_entry = (m_entry * 16 + ((d == 17) ? 0 : d)) % (64'd1 << EW);
                        m_count++;
                    end else m_ovf = 1;
                end else if (d == 16) begin
                    m_entry = 0; m_count = 0;
                end else if (m_count > 0) begin
                    m_committed = m_entry; m_cv = 1; m_entry = 0; m_count = 0;
                end
            end
        end else if (d == 31 && run_len == STABLE) begin
            armed = 1;
        end
    endtask

    task automatic drive(input int d);
        decoded = 5'(d);
        @(posedge clk);
        #1;
        model_step(d);
        if (key_strobe === 1'b1) obs_strobes++;
        if (commit_valid === 1'b1) obs_commits++;
        if (overflow === 1'b1) obs_ovf++;
    endtask

    task automatic press(input int d);
        repeat (STABLE) drive(d);
        repeat (STABLE) drive(31);
    endtask

    task automatic clear_obs();
        obs_strobes = 0; obs_commits = 0; obs_ovf = 0;
    endtask

    task automatic test_reset();
        rst = 1; decoded = 5'd31;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        tests++;
        if ({entry, digit_count, committed} !== '0) begin
            fails++;
            $display("FAIL reset_data entry=%h count=%0d committed=%h required 0/0/0", entry, digit_count, committed);
        end
        tests++;
        if ({commit_valid, key_strobe, overflow, key_code} !== {3'b000, 5'd31}) begin
            fails++;
            $display("FAIL reset_ctrl cv=%b ks=%b ovf=%b code=%0d required 0/0/0/31", commit_valid, key_strobe, overflow, key_code);
        end
        rst = 0;
        $display("[TB] reset checked");
    endtask

    task automatic test_press();
        clear_obs();
        repeat (2) drive(5);
        tests++;
        if (key_strobe !== 1'b0) begin
            fails++; $display("FAIL press_early ks=%b required 0", key_strobe);
        end
        drive(5);
        tests++;
        if (key_strobe !== 1'b1 || key_code !== 5'd5 || entry !== 16'h0005 || digit_count !== 4'd1) begin
            fails++;
            $display("FAIL press_accept ks=%b code=%0d entry=%h count=%0d required 1/5/0005/1", key_strobe, key_code, entry, digit_count);
        end
        repeat (STABLE) drive(31);
        tests++;
        if (obs_strobes !== 1) begin
            fails++; $display("FAIL press_once strobes=%0d required 1", obs_strobes);
        end
        $display("[TB] press 5 -> entry=%h", entry);
    endtask

    task automatic test_bounce();
        clear_obs();
        drive(5); drive(31); drive(5); drive(5); drive(31);
        tests++;
        if (obs_strobes !== 0) begin
            fails++; $display("FAIL bounce_reject strobes=%0d required 0", obs_strobes);
        end
        press(7);
        tests++;
        if (obs_strobes !== 1 || key_code !== 5'd7 || entry !== 16'h0057 || entry !== m_entry[EW-1:0]) begin
            fails++;
            $display("FAIL bounce_accept strobes=%0d code=%0d entry=%h required 1/7/0057", obs_strobes, key_code, entry);
        end
        $display("[TB] bounce then 7 -> entry=%h", entry);
    endtask

    task automatic test_fill_overflow();
        press(16);
        clear_obs();
        press(1); press(2); press(3); press(17);
        tests++;
        if (entry !== 16'h1230 || digit_count !== 4'd4 || obs_ovf !== 0) begin
            fails++;
            $display("FAIL fill entry=%h count=%0d ovf=%0d required 1230/4/0", entry, digit_count, obs_ovf);
        end
        repeat (STABLE) drive(12);
        tests++;
        if (overflow !== 1'b1 || key_strobe !== 1'b1 || key_code !== 5'd12 || entry !== 16'h1230 || digit_count !== 4'd4) begin
            fails++;
            $display("FAIL overflow ovf=%b ks=%b code=%0d entry=%h count=%0d required 1/1/12/1230/4", overflow, key_strobe, key_code, entry, digit_count);
        end
        repeat (STABLE) drive(31);
        tests++;
        if (obs_ovf !== 1 || overflow !== 1'b0) begin
            fails++; $display("FAIL overflow_pulse count=%0d now=%b required 1/0", obs_ovf, overflow);
        end
        $display("[TB] fill -> entry=%h overflow pulses=%0d", entry, obs_ovf);
    endtask

    task automatic test_commit();
        clear_obs();
        repeat (STABLE) drive(18);
        tests++;
        if (commit_valid !== 1'b1 || committed !== 16'h1230 || entry !== 16'h0000 || digit_count !== 4'd0) begin
            fails++;
            $display("FAIL commit cv=%b committed=%h entry=%h count=%0d required 1/1230/0000/0", commit_valid, committed, entry, digit_count);
        end
        repeat (STABLE) drive(31);
        press(18);
        tests++;
        if (obs_commits !== 1 || obs_strobes !== 2 || key_code !== 5'd18 || committed !== 16'h1230) begin
            fails++;
            $display("FAIL commit_empty commits=%0d strobes=%0d code=%0d committed=%h required 1/2/18/1230", obs_commits, obs_strobes, key_code, committed);
        end
        $display("[TB] commit -> committed=%h", committed);
    endtask

    task automatic test_clear_hold();
        press(9); press(9);
        tests++;
        if (entry !== 16'h0099 || digit_count !== 4'd2) begin
            fails++; $display("FAIL digits_99 entry=%h count=%0d required 0099/2", entry, digit_count);
        end
        clear_obs();
        repeat (20) drive(16);
        repeat (5) drive(4);
        repeat (STABLE) drive(31);
        tests++;
        if (obs_strobes !== 1 || entry !== 16'h0000 || digit_count !== 4'd0 || key_code !== 5'd16) begin
            fails++;
            $display("FAIL clear_hold strobes=%0d entry=%h count=%0d code=%0d required 1/0000/0/16", obs_strobes, entry, digit_count, key_code);
        end
        $display("[TB] hold * -> strobes=%0d entry=%h", obs_strobes, entry);
    endtask

    task automatic test_async_reset();
        press(10); press(11);
        tests++;
        if (entry !== 16'h00AB) begin
            fails++; $display("FAIL pre_reset entry=%h required 00AB", entry);
        end
        drive(3);
        #2 rst = 1;
        #1;
        tests++;
        if ({entry, digit_count, committed, commit_valid, key_strobe, overflow} !== '0 || key_code !== 5'd31) begin
            fails++;
            $display("FAIL async_reset entry=%h count=%0d committed=%h ks=%b code=%0d required all 0, code 31", entry, digit_count, committed, key_strobe, key_code);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        clear_obs();
        repeat (2) drive(3);
        tests++;
        if (obs_strobes !== 0) begin
            fails++; $display("FAIL post_reset_early strobes=%0d required 0", obs_strobes);
        end
        drive(3);
        tests++;
        if (key_strobe !== 1'b1 || key_code !== 5'd3 || entry !== 16'h0003) begin
            fails++;
            $display("FAIL post_reset_accept ks=%b code=%0d entry=%h required 1/3/0003", key_strobe, key_code, entry);
        end
        repeat (STABLE) drive(31);
        $display("[TB] async reset -> re-accept 3, entry=%h", entry);
    endtask

    task automatic test_random();
        logic [4:0] vlist [16] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                   5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17, 5'd18};
        int cycles = 0;
        int bad = 0;
        while (cycles < 600) begin
            int sel  = $urandom_range(0, 9);
            int hold = $urandom_range(1, 5);
            int d;
            if (sel <= 5) d = int'(vlist[$urandom_range(0, 15)]);
            else if (sel == 8) d = ($urandom_range(0, 1) == 0) ? $urandom_range(19, 30) : $urandom_range(14, 15);
            else d = 31;
            for (int h = 0; h < hold; h++) begin
                drive(d);
                cycles++;
                tests++;
                if (entry !== m_entry[EW-1:0] || digit_count !== 4'(m_count) ||
                    committed !== m_committed[EW-1:0] || commit_valid !== m_cv ||
                    key_strobe !== m_ks || key_code !== 5'(m_code) || overflow !== m_ovf) begin
                    fails++; bad++;
                    $display("FAIL random cyc=%0d in=%0d got e=%h n=%0d c=%h cv=%b ks=%b k=%0d o=%b required e=%h n=%0d c=%h cv=%b ks=%b k=%0d o=%b",
                             cycles, d, entry, digit_count, committed, commit_valid, key_strobe, key_code, overflow,
                             m_entry[EW-1:0], m_count, m_committed[EW-1:0], m_cv, m_ks, m_code, m_ovf);
                end
            end
        end
        $display("[TB] random %0d cycles, %0d mismatching cycles", cycles, bad);
    endtask

    initial begin
        model_reset();
        clear_obs();
        test_reset();
        test_press();
        test_bounce();
        test_fill_overflow();
        test_commit();
        test_clear_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
